serial_nibble_adder: RTL and testbench
======================================

# serial_nibble_adder

Multi-cycle WIDTH-bit adder/subtractor that processes one 4-bit nibble per clock, LSB nibble first. A registered carry links the nibbles across cycles. It sits between an operand source and a result sink, with valid/ready handshakes on both sides. It reuses a single 4-bit ripple-carry adder slice, which keeps logic area constant regardless of WIDTH.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 8. Define NIB = WIDTH/4.

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A (unsigned or two's complement)
- b  in  WIDTH  operand B
- cin  in  1  carry-in; ignored when sub=1
- sub  in  1  0: A+B+cin; 1: A−B (A + ~B + 1)
- out_valid  out  1  result present
- out_ready  in  1  sink accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of bit WIDTH−1 (in subtract mode, 1 = no borrow)
- overflow  out  1  two's-complement overflow

## Operation
- FSM states are IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture a and b_eff (b_eff = sub ? ~b : b) into shift registers.
  - Set the carry register to sub ? 1 : cin.
  - Capture a[WIDTH−1] and b_eff[WIDTH−1].
  - Clear the nibble counter to 0, then go to RUN.
- RUN, each cycle:
  - Feed the low nibbles of the A/B shift registers plus the carry register to the 4-bit slice.
  - Shift the A/B registers right by 4.
  - Shift the slice sum into the top nibble of the result register, which shifts right by 4.
  - Load the slice carry-out into the carry register and increment the counter.
  - When the counter reaches NIB−1 on this cycle, go to DONE.
- DONE:
  - out_valid=1.
  - sum = result register; cout = carry register.
  - overflow = (a_msb == b_eff_msb) && (sum[WIDTH−1] != a_msb).
  - On out_ready, go to IDLE.
- Arithmetic is modulo 2^WIDTH. Carries propagate across all NIB nibbles, including a full ripple chain such as 0xFFFF+1.
- in_ready=0 in RUN and DONE. in_valid in those states is ignored, and operands are not sampled.
- Outputs stay stable while out_valid=1 and out_ready=0.
- sum, cout and overflow hold their last value outside DONE. They are valid only when out_valid=1.

## Timing
- Reset: the next state is IDLE, with in_ready=1, out_valid=0, and sum, cout, overflow, counter and carry register all 0.
- Reset mid-operation (RUN or DONE) discards the operation. No out_valid is produced for it.
- Latency: accept at edge k; RUN occupies cycles k+1 … k+NIB; out_valid rises in cycle k+NIB+1. For WIDTH=16, out_valid is high 5 cycles after the accept edge.
- Throughput: at best one operation per NIB+2 cycles, with out_ready held high. DONE lasts ≥1 cycle, followed by IDLE for ≥1 cycle. There is no accept in the same cycle as the output handshake.
- in_ready and out_valid are never high in the same cycle.
- All outputs are registered or decoded directly from the state register. There is no combinational path from any input to any output.

## Structure
- Shared package adder_pkg:
  - constant NIB_W = 4
  - typedef of the FSM state enum (IDLE, RUN, DONE)
  - function computing NIB from WIDTH
- Sub-module nibble_adder: a purely combinational 4-bit ripple-carry adder (a, b, cin → sum, cout), instantiated once.
- Top-level concerns: FSM, shift registers, carry register, counter of width $clog2(NIB), overflow logic.

## Test plan
WIDTH=16 throughout, out_ready=1 unless stated.
- a=0x1234, b=0x4321, cin=0, sub=0 → sum=0x5555, cout=0, overflow=0; out_valid exactly 5 cycles after accept.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, overflow=0. This checks carry across all 4 nibble boundaries.
- a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, overflow=1. Then cin=1 with a=b=0x0000 → sum=0x0001.
- Subtract mode:
  - sub=1, a=0x0005, b=0x0007, cin=1 (must be ignored) → sum=0xFFFE, cout=0, overflow=0.
  - sub=1, a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, overflow=1.
- Backpressure:
  - Hold out_ready=0 for 3 cycles in DONE → out_valid, sum and flags stay constant, in_ready=0, and new in_valid operands are not captured.
  - After the handshake, in_ready=1 the next cycle, and the next op result is correct.
- Reset:
  - Assert rst for 1 cycle during RUN cycle 2 → the following cycle shows in_ready=1, out_valid=0, sum=0.
  - No stale result appears afterwards.
  - A subsequent op 0x00FF+0x0001 → 0x0100.

Source files
------------

// File: rtl/adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | adder_pkg
// | Shared constants, FSM state type and helpers for the serial nibble adder.
// | Rev 1.0
// +----------------------------------------------------------------------------
package adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nib_count(input int width);
        return width / NIB_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | nibble_adder
// | Purely combinational 4-bit ripple-carry adder slice.
// | Rev 1.0
// +----------------------------------------------------------------------------
module nibble_adder
    import adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W:0] w_c;

    assign w_c[0] = cin;

    generate
        for (genvar i = 0; i < NIB_W; i++) begin : g_bit
            assign sum[i]     = a[i] ^ b[i] ^ w_c[i];
            assign w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = w_c[NIB_W];

endmodule
`default_nettype wire

// File: rtl/serial_nibble_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | serial_nibble_adder
// | WIDTH-bit add/subtract, one nibble per clock through a single 4-bit slice.
// | Rev 1.0
// +----------------------------------------------------------------------------
module serial_nibble_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16   // multiple of 4, at least 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int CNT_W = $clog2(NIB);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(NIB - 1);

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0]       r_a_sh;
    logic [WIDTH-1:0]       r_b_sh;
    logic [WIDTH-NIB_W-1:0] r_acc;
    logic [WIDTH-1:0]       r_sum;
    logic                   r_carry;
    logic                   r_cout;
    logic                   r_ovf;
    logic                   r_a_msb;
    logic                   r_b_msb;
    logic [CNT_W-1:0]       r_cnt;

    logic [NIB_W-1:0]       w_slice_sum;
    logic                   w_slice_cout;
    logic [WIDTH-1:0]       w_b_eff;
    logic [WIDTH-1:0]       w_res_nxt;
    logic                   w_accept;
    logic                   w_last;

    assign w_b_eff   = sub ? ~b : b;
    assign w_accept  = (r_state == IDLE) && in_valid;
    assign w_last    = (r_state == RUN) && (r_cnt == c_last_cnt);
    // Slice result enters at the top; after NIB shifts the LSB nibble sits at bit 0.
    assign w_res_nxt = {w_slice_sum, r_acc};

    nibble_adder u_slice (
        .a    (r_a_sh[NIB_W-1:0]),
        .b    (r_b_sh[NIB_W-1:0]),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= w_b_eff;
            r_carry <= sub ? 1'b1 : cin;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= w_b_eff[WIDTH-1];
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a_sh  <= r_a_sh >> NIB_W;
            r_b_sh  <= r_b_sh >> NIB_W;
            r_acc   <= w_res_nxt[WIDTH-1:NIB_W];
            r_carry <= w_slice_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
            // Output registers update only here so they hold through IDLE and RUN.
            if (w_last) begin
                r_sum  <= w_res_nxt;
                r_cout <= w_slice_cout;
                r_ovf  <= (r_a_msb == r_b_msb) && (w_res_nxt[WIDTH-1] != r_a_msb);
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_nibble_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_serial_nibble_adder
// | Scoreboard bench: directed and random operations against a full-width model.
// | Rev 1.0
// +----------------------------------------------------------------------------
module tb_serial_nibble_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    serial_nibble_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Whole-word reference: A + B_eff + carry_in computed in W+1 bits.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                   input logic tcin, input logic tsub);
        exp_t         r;
        logic [W-1:0] be;
        logic [W:0]   full;
        be   = tsub ? ~tb_ : tb_;
        full = {1'b0, ta} + {1'b0, be} + {{W{1'b0}}, (tsub ? 1'b1 : tcin)};
        r.s  = full[W-1:0];
        r.co = full[W];
        r.ov = (ta[W-1] == be[W-1]) && (r.s[W-1] != ta[W-1]);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("ready_valid_exclusive", {31'd0, in_ready & out_valid}, 32'd0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sum", {16'd0, sum}, {16'd0, e.s});
                    check("cout", {31'd0, cout}, {31'd0, e.co});
                    check("overflow", {31'd0, overflow}, {31'd0, e.ov});
                end
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_before_op", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tcin, input logic tsub, input int stall);
        logic [W+1:0] snap;
        wait_ready();
        a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
        sb.push_back(model(ta, tb_, tcin, tsub));
        tick();
        in_valid = 1'b0;
        if (stall > 0) out_ready = 1'b0;
        for (int c = 1; c <= NIB + 1; c++) begin
            check("latency_out_valid", {31'd0, out_valid}, {31'd0, (c == NIB + 1)});
            check("busy_in_ready", {31'd0, in_ready}, 32'd0);
            if (c < NIB + 1) tick();
        end
        snap = {sum, cout, overflow};
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            tick();
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_outputs_stable", {14'd0, sum, cout, overflow}, {14'd0, snap});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("post_handshake_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_handshake_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_sum", {16'd0, sum}, 32'd0);
        check("reset_flags", {30'd0, cout, overflow}, 32'd0);
        rst = 1'b0;
        tick();

        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        do_op(16'h0000, 16'h0000, 1'b1, 1'b0, 0);
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);

        // Backpressure then an immediate follow-up op.
        do_op(16'h1111, 16'h2222, 1'b1, 1'b0, 3);
        do_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 0);

        // Reset during the second RUN cycle discards the operation.
        wait_ready();
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun_reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrun_reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrun_reset_sum", {16'd0, sum}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("no_stale_output", {31'd0, out_valid}, 32'd0);
        end
        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'h0001 : W'($urandom);
            do_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        tick(); tick();
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
